// File: rtl/a2d_rr_intf.sv
// Round-robin ADC128S reader: channels 0,4,5,6 -> lft_ld, rght_ld, steer_pot, batt.
// Optional macro A2D_LD_LPF_EN adds a first-order low-pass filter on the load cell results.
//
// state | meaning
// IDLE  | waiting for nxt
// CMD   | first SPI transaction, addresses the channel, response discarded
// GAP   | SS_n held high between transactions
// READ  | second SPI transaction, response holds the addressed channel
// DONE  | result written, cnv_cmplt pulsed
module a2d_rr_intf #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF    = SCLK_DIV / 2;
  localparam int TXN_LEN = 16 * SCLK_DIV + HALF;
  localparam int CW      = $clog2(TXN_LEN);
  localparam int DW      = $clog2(SCLK_DIV);

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          gap_cnt;
  logic [15:0]   tx_sr;
  logic [11:0]   rx_sr;
  logic [1:0]    idx;
  logic [2:0]    ch;
  logic [15:0]   cmd;
  logic          txn_last;
  logic          sclk_fall;
  logic          sclk_rise;
  logic          first_bit;

  always_comb begin
    ch        = (idx == 2'd0) ? 3'd0 : 3'd3 + {1'b0, idx};
    cmd       = {2'b00, ch, 11'h000};
    cnt_n     = cnt + CW'(1);
    txn_last  = (cnt == CW'(TXN_LEN - 1));
    sclk_fall = (cnt_n[DW-1:0] == DW'(HALF));
    sclk_rise = (cnt_n[DW-1:0] == '0);
    first_bit = (cnt_n[CW-1:DW] == '0);
  end

`ifdef A2D_LD_LPF_EN
  logic lft_seen;
  logic rght_seen;

  function automatic logic [11:0] lpf(input logic [11:0] cur, input logic [11:0] smp);
    logic signed [12:0] diff;
    logic signed [12:0] sum;
    diff = $signed({1'b0, smp}) - $signed({1'b0, cur});
    diff = diff >>> 2;
    sum  = $signed({1'b0, cur}) + diff;
    return sum[11:0];
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_cnt   <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      idx       <= 2'd0;
      lft_ld    <= '0;
      rght_ld   <= '0;
      steer_pot <= '0;
      batt      <= '0;
      cnv_cmplt <= 1'b0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      MOSI      <= 1'b0;
`ifdef A2D_LD_LPF_EN
      lft_seen  <= 1'b0;
      rght_seen <= 1'b0;
`endif
    end else begin
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: begin
          if (nxt) begin
            state <= CMD;
            SS_n  <= 1'b0;
            cnt   <= '0;
            tx_sr <= cmd;
            MOSI  <= cmd[15];
          end
        end
        CMD, READ: begin
          if (txn_last) begin
            SS_n <= 1'b1;
            SCLK <= 1'b1;
            cnt  <= '0;
            if (state == CMD) begin
              state   <= GAP;
              gap_cnt <= 1'b1;
            end else begin
              state     <= DONE;
              cnv_cmplt <= 1'b1;
              idx       <= idx + 2'd1;
              case (idx)
`ifdef A2D_LD_LPF_EN
                2'd0: begin
                  lft_ld   <= lft_seen ? lpf(lft_ld, rx_sr) : rx_sr;
                  lft_seen <= 1'b1;
                end
                2'd1: begin
                  rght_ld   <= rght_seen ? lpf(rght_ld, rx_sr) : rx_sr;
                  rght_seen <= 1'b1;
                end
`else
                2'd0: lft_ld  <= rx_sr;
                2'd1: rght_ld <= rx_sr;
`endif
                2'd2: steer_pot <= rx_sr;
                default: batt <= rx_sr;
              endcase
            end
          end else begin
            cnt <= cnt_n;
            if (sclk_fall) begin
              SCLK <= 1'b0;
              // bit 15 is already on MOSI from SS_n fall, so the first fall holds it
              if (!first_bit) begin
                MOSI  <= tx_sr[14];
                tx_sr <= {tx_sr[14:0], 1'b0};
              end
            end else if (sclk_rise) begin
              SCLK  <= 1'b1;
              rx_sr <= {rx_sr[10:0], MISO};
            end
          end
        end
        GAP: begin
          if (gap_cnt == 1'b0) begin
            state <= READ;
            SS_n  <= 1'b0;
            tx_sr <= cmd;
            MOSI  <= cmd[15];
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Self-checking bench for a2d_rr_intf with a behavioural ADC128S model and result scoreboard.
// Build with A2D_LD_LPF_EN defined to exercise the load cell filter expectations.
module tb_a2d_rr_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        MISO = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        cnv_cmplt, SS_n, SCLK, MOSI;

  always #5 clk = ~clk;

  a2d_rr_intf #(.SCLK_DIV(32)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .cnv_cmplt(cnv_cmplt), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_cmplt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC model: answers each transaction with the channel addressed by the previous one
  logic [11:0] vals [8];
  logic [2:0]  last_addr = 3'd0;
  logic [15:0] miso_word = '0;
  logic [15:0] cmd_sh = '0;
  int          r_cnt = 0;
  logic [15:0] cmdq [$];

  always @(negedge SS_n) begin
    r_cnt     = 0;
    cmd_sh    = '0;
    miso_word = {4'h0, vals[last_addr]};
    MISO      = miso_word[15];
  end

  always @(posedge SCLK) if (!SS_n) begin
    cmd_sh = {cmd_sh[14:0], MOSI};
    r_cnt++;
  end

  always @(negedge SCLK) if (!SS_n && r_cnt > 0 && r_cnt < 16) MISO = miso_word[15 - r_cnt];

  always @(posedge SS_n) if (r_cnt == 16) begin
    last_addr = cmd_sh[13:11];
    cmdq.push_back(cmd_sh);
    r_cnt = 0;
  end

  typedef struct {
    int          idx;
    logic [11:0] val;
    int          start;
  } exp_t;
  exp_t sbq [$];

  int          ptr = 0;
  logic [11:0] mdl_lft = '0, mdl_rght = '0;
  bit          mdl_lft_seen = 0, mdl_rght_seen = 0;

  function automatic int ch_of(input int idx);
    return (idx == 0) ? 0 : idx + 3;
  endfunction

`ifdef A2D_LD_LPF_EN
  function automatic logic [11:0] mdl_lpf(input logic [11:0] cur, input logic [11:0] s);
    int d;
    d = int'(s) - int'(cur);
    d = d >>> 2;
    return 12'(int'(cur) + d);
  endfunction
`endif

  task automatic push_exp(input int idx, input int start);
    exp_t e;
    e.idx   = idx;
    e.start = start;
    e.val   = vals[ch_of(idx)];
`ifdef A2D_LD_LPF_EN
    if (idx == 0) begin
      e.val = mdl_lft_seen ? mdl_lpf(mdl_lft, e.val) : e.val;
      mdl_lft = e.val;
      mdl_lft_seen = 1;
    end else if (idx == 1) begin
      e.val = mdl_rght_seen ? mdl_lpf(mdl_rght, e.val) : e.val;
      mdl_rght = e.val;
      mdl_rght_seen = 1;
    end
`endif
    sbq.push_back(e);
  endtask

  function automatic logic [11:0] reg_of(input int idx);
    case (idx)
      0:       return lft_ld;
      1:       return rght_ld;
      2:       return steer_pot;
      default: return batt;
    endcase
  endfunction

  always @(negedge clk) if (rst_n && cnv_cmplt) begin
    exp_t e;
    n_cmplt++;
    if (sbq.size() == 0) begin
      check_eq("cmplt_unexpected", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check_eq("latency", cyc - e.start, 1059);
      check_eq($sformatf("result_idx%0d", e.idx), reg_of(e.idx), e.val);
    end
  end

  // SPI protocol monitor
  bit prev_ss = 1, prev_sclk = 1, prev_mosi = 0;
  int ss_cnt = 0, rise_cnt = 0, n_txn = 0, bad_w = 0, bad_r = 0, bad_mosi = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ss_cnt   = 0;
      rise_cnt = 0;
      prev_ss  = 1;
    end else begin
      if (!SS_n) begin
        ss_cnt++;
        if (!prev_sclk && SCLK) rise_cnt++;
        if (!prev_ss && (MOSI !== prev_mosi) && !(prev_sclk && !SCLK)) bad_mosi++;
      end else if (!prev_ss) begin
        n_txn++;
        if (ss_cnt != 528) bad_w++;
        if (rise_cnt != 16) bad_r++;
        ss_cnt   = 0;
        rise_cnt = 0;
      end
      prev_ss = SS_n;
    end
    prev_sclk = SCLK;
    prev_mosi = MOSI;
  end

  task automatic clear_mon();
    n_txn = 0; bad_w = 0; bad_r = 0; bad_mosi = 0;
  endtask

  task automatic reset_model();
    sbq.delete();
    ptr = 0;
    mdl_lft_seen = 0;
    mdl_rght_seen = 0;
    mdl_lft = '0;
    mdl_rght = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_nxt(output int start);
    @(negedge clk);
    nxt = 1'b1;
    start = cyc;
    push_exp(ptr, start);
    ptr = (ptr + 1) % 4;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check_eq("timeout", 32'd1, 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [11:0] lft_tbl [4];
  int s, base_cmplt;

  initial begin
    for (int i = 0; i < 8; i++) vals[i] = 12'h0A0 + 12'(i);
    vals[0] = 12'h300; vals[4] = 12'h2F0; vals[5] = 12'h800; vals[6] = 12'hC00;
`ifdef A2D_LD_LPF_EN
    lft_tbl[0] = 12'h000; lft_tbl[1] = 12'h100; lft_tbl[2] = 12'h1C0; lft_tbl[3] = 12'h250;
`else
    lft_tbl[0] = 12'h000; lft_tbl[1] = 12'h400; lft_tbl[2] = 12'h400; lft_tbl[3] = 12'h400;
`endif

    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_lft", lft_ld, 0);
    check_eq("rst_rght", rght_ld, 0);
    check_eq("rst_steer", steer_pot, 0);
    check_eq("rst_batt", batt, 0);
    check_eq("rst_cmplt", cnv_cmplt, 0);
    check_eq("rst_ss_n", SS_n, 1);
    check_eq("rst_sclk", SCLK, 1);
    check_eq("rst_mosi", MOSI, 0);
    rst_n = 1'b1;

    // one conversion per channel
    clear_mon();
    cmdq.delete();
    for (int i = 0; i < 4; i++) begin
      pulse_nxt(s);
      wait_idle(1200);
    end
    check_eq("cmplt_count", n_cmplt, 4);
    check_eq("final_lft", lft_ld, 12'h300);
    check_eq("final_rght", rght_ld, 12'h2F0);
    check_eq("final_steer", steer_pot, 12'h800);
    check_eq("final_batt", batt, 12'hC00);
    check_eq("txn_count", n_txn, 8);
    check_eq("ss_width_bad", bad_w, 0);
    check_eq("sclk_rises_bad", bad_r, 0);
    check_eq("mosi_unstable", bad_mosi, 0);
    check_eq("cmd_count", cmdq.size(), 8);
    if (cmdq.size() >= 8) begin
      check_eq("cmd_ch0", cmdq[0], 16'h0000);
      check_eq("cmd_ch0_read", cmdq[1], 16'h0000);
      check_eq("cmd_ch4", cmdq[2], 16'h2000);
      check_eq("cmd_ch5", cmdq[4], 16'h2800);
      check_eq("cmd_ch6", cmdq[7], 16'h3000);
    end

    // nxt held high: only IDLE accepts it
    vals[0] = 12'h5A5;
    vals[4] = 12'h1E1;
    cmdq.delete();
    base_cmplt = n_cmplt;
    @(negedge clk);
    nxt = 1'b1;
    s = cyc;
    push_exp(0, s);
    push_exp(1, s + 1060);
    ptr = 2;
    repeat (2000) @(negedge clk);
    nxt = 1'b0;
    wait_idle(400);
    repeat (1200) @(negedge clk);
    check_eq("held_cmplt_count", n_cmplt - base_cmplt, 2);
    check_eq("held_cmd_count", cmdq.size(), 4);
    if (cmdq.size() >= 4) begin
      check_eq("held_cmd_first", cmdq[0], 16'h0000);
      check_eq("held_cmd_second", cmdq[2], 16'h2000);
    end

    // async reset in the middle of a channel-4 conversion
    do_reset();
    pulse_nxt(s);
    wait_idle(1200);
    pulse_nxt(s);
    while (cyc < s + 700) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ss_n", SS_n, 1);
    check_eq("arst_sclk", SCLK, 1);
    check_eq("arst_lft", lft_ld, 0);
    check_eq("arst_rght", rght_ld, 0);
    check_eq("arst_cmplt", cnv_cmplt, 0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    cmdq.delete();
    pulse_nxt(s);
    wait_idle(1200);
    check_eq("arst_restart_cmd_count", cmdq.size(), 2);
    if (cmdq.size() >= 2) check_eq("arst_restart_ch0", cmdq[1], 16'h0000);

    // load cell filter sequence
    do_reset();
    vals[4] = 12'h2F0;
    for (int r = 0; r < 4; r++) begin
      vals[0] = (r == 0) ? 12'h000 : 12'h400;
      vals[6] = 12'h100 * 12'(r + 1) + 12'(r);
      for (int i = 0; i < 4; i++) begin
        pulse_nxt(s);
        wait_idle(1200);
      end
      check_eq($sformatf("lpf_lft_%0d", r), lft_ld, lft_tbl[r]);
      check_eq($sformatf("raw_batt_%0d", r), batt, vals[6]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/a2d_rr_intf.md
# a2d_rr_intf

Round-robin interface to the ADC128S 8-channel A2D that supplies left/right load cell, steering potentiometer and battery readings to the Segway balance/steer logic. On each `nxt` request it runs one two-transaction SPI conversion on the next channel in a fixed rotation and updates that channel's 12-bit result register. It sits directly upstream of the steer-enable, balance-control and battery-monitor stages and drives the `A2D_SS_n/SCLK/MOSI/MISO` pins.

## Interface
- `SCLK_DIV`, default 32: `clk` cycles per SCLK period; must be a power of two, ≥4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `nxt`  in  1  single-cycle request to start the next conversion.
- `lft_ld`  out  12  latest left load cell result, channel 0.
- `rght_ld`  out  12  latest right load cell result, channel 4.
- `steer_pot`  out  12  latest steering pot result, channel 5.
- `batt`  out  12  latest battery result, channel 6.
- `cnv_cmplt`  out  1  one-cycle pulse when a result register updates.
- `SS_n`  out  1  A2D slave select, active low.
- `SCLK`  out  1  A2D serial clock.
- `MOSI`  out  1  A2D serial data out.
- `MISO`  in  1  A2D serial data in.

## Operation
- Channel rotation: 0 → 4 → 5 → 6 → 0. The pointer advances only on conversion completion.
- Main FSM states: IDLE, CMD, GAP, READ, DONE.
- IDLE: `nxt` high moves the FSM to CMD.
- CMD: sends the 16-bit word `{2'b00, ch[2:0], 11'h000}`. The returned data is discarded.
- GAP: holds `SS_n` high for 2 clk.
- READ: sends the same command word. The result is `rx[11:0]`; `rx[15:12]` is ignored.
- DONE: writes the result to the register for the current channel, pulses `cnv_cmplt`, advances the pointer, and returns to IDLE.
- `nxt` is ignored in every state except IDLE. It is neither queued nor counted.
- The other three result registers hold their values during and after a conversion.
- SPI bit order is MSB first, 16 bits per transaction.
- SPI idle levels: `SS_n`=1, `SCLK`=1.
- MOSI changes only on SCLK fall.
- MISO is sampled on SCLK rise.
- The received word is MISO bits 15..0, in rise order 1..16.

## Timing
- Reset values:
  - `lft_ld`, `rght_ld`, `steer_pot`, `batt` = 12'h000.
  - `cnv_cmplt` = 0, `SS_n` = 1, `SCLK` = 1, `MOSI` = 0.
  - Channel pointer = channel 0; FSM in IDLE.
- Cycle 0 is the cycle in which `nxt` is sampled high.
- CMD transaction:
  - `SS_n` low for cycles 1–528.
  - SCLK falls at cycle 1+SCLK_DIV/2+SCLK_DIV·k and rises at cycle 1+SCLK_DIV·(k+1), for k=0..15. With the default, falls are at 17,49,… and rises at 33,…,513.
  - MOSI bit 15 is valid from cycle 1.
- GAP: `SS_n` high for cycles 529–530.
- READ transaction: `SS_n` low for cycles 531–1058, same edge pattern offset by 530.
- Completion: at cycle 1059 `SS_n` rises, the result register updates and `cnv_cmplt` is high for exactly that cycle.
- Earliest accepted next `nxt`: cycle 1060.
- Total latency with default SCLK_DIV: 1059 clk from `nxt` to result.
- Async `rst_n` assertion mid-conversion:
  - All outputs return to reset values immediately.
  - The partial result is discarded.
  - The conversion restarts from channel 0.

## Configuration
- Macro `A2D_LD_LPF_EN`.
- Defined: `lft_ld` and `rght_ld` are first-order filtered. On each update, `reg = reg + ((sample − reg) >>> 2)`, using 13-bit signed intermediate arithmetic and truncating to 12 bits. The first update after reset loads the raw sample.
- Defined: `steer_pot` and `batt` are always raw.
- Undefined: all four registers load the raw sample. No filter logic is synthesized.

## Test plan
- Reset then 4 `nxt` pulses, ADC model with lft=12'h300, rght=12'h2F0, steer=12'h800, batt=12'hC00 → registers equal those values in that order, one `cnv_cmplt` each, each 1059 clk after its `nxt`.
- `nxt` held high for 2000 cycles → exactly one conversion starts at cycle 0 and the next at cycle 1060; pointer order is 0,4,5,6.
- Protocol check with SCLK_DIV=32:
  - `SS_n` low width is 528.
  - There are 16 SCLK rises per transaction.
  - The command word is 16'h0000 for channel 0 and 16'h2000 for channel 4.
  - MOSI is stable across every rise.
- `rst_n` pulsed low at cycle 700 of a channel-4 conversion:
  - `SS_n`=1, `SCLK`=1 and all registers are 0 asynchronously.
  - The next `nxt` converts channel 0.
- `A2D_LD_LPF_EN` defined, lft source 12'h000 then 12'h400:
  - Successive `lft_ld` values are 0x000, 0x100, 0x1C0, 0x250.
  - `batt` tracks raw values.
- Macro undefined, same stimulus → `lft_ld` = 0x400 after the first channel-0 update.
